// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: UART transmitter that pops words from a show-ahead FIFO and sends 8N1-style frames
// Ports:
//   i_clk      clock
//   i_reset_n  asynchronous active-low reset
//   i_empty    FIFO empty flag
//   i_rdata    FIFO head word, valid while i_empty=0
//   o_rd       FIFO pop strobe, one cycle per consumed word
//   o_tx       serial line, idle high
//   o_busy     high while a frame is in progress
//   o_done     one-cycle pulse on the final cycle of the last stop bit
module uart_fifo_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_empty,
    input  logic [DATA_BITS-1:0] i_rdata,
    output logic                 o_rd,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int SL = STOP_BITS * CLKS_PER_BIT;
    localparam int SW = $clog2(SL);
    localparam int IW = $clog2(DATA_BITS) + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          stop_q, stop_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    // Gated by reset so no pop can be seen while the block is held in reset.
    assign o_rd    = (state_q == IDLE) & ~i_empty & i_reset_n;
    assign o_tx    = tx_q;
    assign o_busy  = state_q != IDLE;
    assign o_done  = done_q;
    assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_empty) begin
                    state_d = START;
                    shift_d = i_rdata;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        stop_d  = '0;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_d[0];
                    end
                end
            end
            default: begin
                stop_d = stop_q + 1'b1;
                // Registered pulse: raise it one cycle early so it lands on the last stop cycle.
                done_d = stop_q == SW'(SL - 2);
                if (stop_q == SW'(SL - 1)) begin
                    state_d = IDLE;
                    stop_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stop_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Serial UART transmitter that drains the team's byte FIFO from its read side. Whenever the FIFO is non-empty and the line is idle, it pops one word and shifts it out as one frame: start bit, data LSB-first, stop bit(s). It is the consumer end of the TX FIFO, sitting between the FIFO and the board's serial TX pin.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame; must equal the FIFO word width.
- `CLKS_PER_BIT`, default 868: clock cycles per bit, i.e. 100 MHz / 115200. Legal range is ≥ 2.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `i_clk`, in, 1: clock.
- `i_reset_n`, in, 1: reset. Asynchronous, active-low.
- `i_empty`, in, 1: FIFO empty flag.
- `i_rdata`, in, DATA_BITS: FIFO head word. It is show-ahead: valid whenever `i_empty`=0.
- `o_rd`, out, 1: FIFO pop strobe, one cycle per consumed word.
- `o_tx`, out, 1: serial line, idle high.
- `o_busy`, out, 1: 1 while a frame is in progress.
- `o_done`, out, 1: one-cycle pulse on the final cycle of the last stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `o_rd` = (state==IDLE) & ~`i_empty`. This is combinational.
  - On that cycle, latch `i_rdata` into the shift register, clear the bit counter and index, and go to START.
  - `o_rd` is never asserted while `i_empty`=1 or outside IDLE.
- START: drive `o_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
- DATA:
  - Drive `o_tx`=shift[0] for CLKS_PER_BIT cycles, then shift right.
  - After DATA_BITS bits, go to STOP.
- STOP:
  - Drive `o_tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - Assert `o_done` on the final cycle, then go to IDLE.
- Counter widths:
  - Bit-cycle counter is $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1.
  - Stop counter covers STOP_BITS×CLKS_PER_BIT.
  - Bit index is $clog2(DATA_BITS)+1 bits.
- Derived outputs:
  - `o_busy` = state≠IDLE.
  - `o_tx` comes from a register.
- Changes on `i_empty` or `i_rdata` mid-frame are ignored; the latched word is used.
- Reset (`i_reset_n`=0, any time, including mid-frame):
  - Immediately: state=IDLE, `o_tx`=1, `o_busy`=0, `o_done`=0, `o_rd`=0, all counters and the shift register cleared.
  - A partially sent word is dropped, not re-read.
  - After release, the first pop can occur on the first clock edge with `i_empty`=0.

## Timing
- Pop cycle: cycle P, `o_rd`=1 in IDLE.
- Start bit: `o_tx` falls at edge P+1 and stays 0 for cycles P+1..P+CLKS_PER_BIT.
- Data bit k: occupies cycles P+1+(k+1)×CLKS_PER_BIT .. P+(k+2)×CLKS_PER_BIT.
- Frame length: (1+DATA_BITS+STOP_BITS)×CLKS_PER_BIT cycles, from P+1 through the `o_done` cycle.
- Back-to-back frames: exactly one IDLE cycle (the next pop cycle) separates the `o_done` cycle from the next start bit. During it `o_tx`=1.
- FIFO `o_empty` updates the cycle after `o_rd`. Because the block is then in START, no double pop is possible.

## Test plan
- **Reset values:** assert `i_reset_n`=0 mid-DATA, with CLKS_PER_BIT=4 → `o_tx`=1, `o_busy`=0, `o_rd`=0 asynchronously. Then release with `i_empty`=1 → `o_tx` stays 1 and `o_rd` stays 0 indefinitely.
- **Single byte:** CLKS_PER_BIT=4, word 0xA5 → exactly one `o_rd` pulse. `o_tx` sequence per 4-cycle bit is 0, 1,0,1,0,0,1,0,1, 1. `o_done` pulses at cycle P+40, and `o_busy` is high P+1..P+40.
- **Back-to-back:** FIFO holds 0x00, 0xFF, 0x3C → three `o_rd` pulses 41 cycles apart. A receiver model decodes 0x00, 0xFF, 0x3C in order. Exactly one idle-high cycle separates the frames, and `o_rd` stays 0 once `i_empty`=1.
- **Two stop bits:** STOP_BITS=2, word 0x81 → frame is 44 cycles, stop high for 8 cycles, then `o_done`.
- **Mid-frame input change:** change `i_rdata` and toggle `i_empty` during DATA for word 0x5A → the line still carries 0x5A and no extra `o_rd` occurs.
- **Reset mid-frame, then resume:** reset during bit 3 of 0x96, with 0x69 queued → after release, the next frame carries the current FIFO head (0x69). No partial retransmission of 0x96 occurs.
